// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared types and constants for the prefix control decoder.
//   alu_op_e   : ALU operation encoding
//   OP_*       : opcode values for the base (level 0) and prefixed tables
//   ctrl_t     : bundle of datapath enables, ALU op, bank and illegal flag
//   CTRL_NOP   : all-zero control word
package ctrl_pkg;

   typedef enum logic [2:0] {
      ALU_ADD  = 3'b000,
      ALU_SUB  = 3'b001,
      ALU_XOR  = 3'b010,
      ALU_RXOR = 3'b011,
      ALU_SLL  = 3'b100,
      ALU_SRL  = 3'b101,
      ALU_AND  = 3'b110
   } alu_op_e;

   // Base table (level 0)
   localparam logic [2:0] OP_PREP = 3'b000;
   localparam logic [2:0] OP_INC  = 3'b001;
   localparam logic [2:0] OP_XOR  = 3'b010;
   localparam logic [2:0] OP_XORR = 3'b011;
   localparam logic [2:0] OP_SLL  = 3'b100;
   localparam logic [2:0] OP_SRL  = 3'b101;

   // Prefixed table (level >= 1)
   localparam logic [2:0] OP_ANDI = 3'b000;
   localparam logic [2:0] OP_BEQ  = 3'b001;
   localparam logic [2:0] OP_LW   = 3'b010;
   localparam logic [2:0] OP_SW   = 3'b011;
   localparam logic [2:0] OP_SAVE = 3'b100;
   localparam logic [2:0] OP_PSFT = 3'b101;
   localparam logic [2:0] OP_PEXT = 3'b110;

   // Bank field is sized for the widest supported level; the top truncates
   // it to its own level width.
   localparam int MAX_LVLW = 4;

   typedef struct packed {
      logic                writePrepReg;
      logic                readPrepReg;
      logic                writeEnabled;
      logic                dataWrite;
      logic                dataRead;
      logic                branch;
      logic                illegal;
      alu_op_e             aluOp;
      logic [MAX_LVLW-1:0] memBank;
   } ctrl_t;

   localparam ctrl_t CTRL_NOP = ctrl_t'('0);

   // Illegal opcode: every enable off, only the flag raised.
   function automatic ctrl_t ctrlIllegal();
      ctrl_t c;
      c         = CTRL_NOP;
      c.illegal = 1'b1;
      return c;
   endfunction

endpackage

// File: rtl/prefix_level_ctr.sv
// prefix_level_ctr: prefix level register plus saturating error counter.
//   clk      : clock, rising edge
//   reset    : asynchronous, active-low
//   inc      : level <= level + 1
//   hold     : level <= level
//   clear    : level <= 0 (wins over inc/hold; none asserted also clears)
//   errInc   : bump errCount, sticking at all-ones
//   level    : current prefix level
//   errCount : saturating illegal-opcode count
module prefix_level_ctr #(
   parameter int LVLW = 2,
   parameter int ERRW = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            inc,
   input  logic            hold,
   input  logic            clear,
   input  logic            errInc,
   output logic [LVLW-1:0] level,
   output logic [ERRW-1:0] errCount
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         level <= '0;
      end else if (clear) begin
         level <= '0;
      end else if (inc) begin
         level <= level + LVLW'(1);
      end else if (hold) begin
         level <= level;
      end else begin
         level <= '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         errCount <= '0;
      end else if (errInc && (errCount != '1)) begin
         errCount <= errCount + ERRW'(1);
      end
   end

endmodule

// File: rtl/prefix_ctrl_decoder.sv
// prefix_ctrl_decoder: zero-latency instruction control decoder with a
// stacked-prefix state machine.
//   clk, reset        : clock / async active-low reset
//   instr_valid,stall : instruction consumed when valid and not stalled
//   opcode, last_bit  : instruction opcode and LSB (INC vs DEC)
//   write_prep_reg .. branch : datapath enables
//   alu_op            : ALU operation
//   mem_bank          : LW/SW bank (level-1), else 0
//   prep_level        : registered prefix level
//   illegal           : illegal opcode consumed this cycle
//   err_count         : saturating illegal count
module prefix_ctrl_decoder
   import ctrl_pkg::*;
#(
   parameter  int OPW          = 3,
   parameter  int PREFIX_DEPTH = 2,
   localparam int LVLW         = $clog2(PREFIX_DEPTH + 1),
   parameter  int ERRW         = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            instr_valid,
   input  logic            stall,
   input  logic [OPW-1:0]  opcode,
   input  logic            last_bit,
   output logic            write_prep_reg,
   output logic            read_prep_reg,
   output logic            write_enabled,
   output logic            data_write,
   output logic            data_read,
   output logic            branch,
   output logic [2:0]      alu_op,
   output logic [LVLW-1:0] mem_bank,
   output logic [LVLW-1:0] prep_level,
   output logic            illegal,
   output logic [ERRW-1:0] err_count
);

   function automatic ctrl_t decodeBase(input logic [2:0] op, input logic lastBit);
      ctrl_t c;
      c = CTRL_NOP;
      case (op)
         OP_PREP: begin c.writePrepReg = 1'b1; c.writeEnabled = 1'b1; end
         OP_INC:  begin c.writeEnabled = 1'b1; c.aluOp = lastBit ? ALU_ADD : ALU_SUB; end
         OP_XOR:  begin c.writeEnabled = 1'b1; c.aluOp = ALU_XOR;  end
         OP_XORR: begin c.writeEnabled = 1'b1; c.aluOp = ALU_RXOR; end
         OP_SLL:  begin c.writeEnabled = 1'b1; c.aluOp = ALU_SLL;  end
         OP_SRL:  begin c.writeEnabled = 1'b1; c.aluOp = ALU_SRL;  end
         default: c = ctrlIllegal();
      endcase
      return c;
   endfunction

   function automatic ctrl_t decodePrefix(input logic [2:0] op, input logic [LVLW-1:0] lvl);
      ctrl_t c;
      c             = CTRL_NOP;
      c.readPrepReg = 1'b1;
      case (op)
         OP_ANDI: begin c.writeEnabled = 1'b1; c.aluOp = ALU_AND; end
         OP_BEQ:  begin c.branch = 1'b1; c.aluOp = ALU_XOR; end
         OP_LW:   begin
            c.writeEnabled = 1'b1;
            c.dataRead     = 1'b1;
            c.memBank      = MAX_LVLW'(lvl - LVLW'(1));
         end
         OP_SW:   begin
            c.dataWrite = 1'b1;
            c.memBank   = MAX_LVLW'(lvl - LVLW'(1));
         end
         OP_SAVE: c.writeEnabled = 1'b1;
         OP_PSFT: begin c.writePrepReg = 1'b1; c.writeEnabled = 1'b1; c.aluOp = ALU_SLL; end
         OP_PEXT: begin
            // No room for another prefix level: treat as illegal and abort.
            if (lvl == LVLW'(PREFIX_DEPTH)) c = ctrlIllegal();
            else c.writePrepReg = 1'b1;
         end
         default: c = ctrlIllegal();
      endcase
      return c;
   endfunction

   logic            fire;
   logic            opHigh;
   logic [2:0]      opLow;
   logic [LVLW-1:0] level;
   ctrl_t           ctrl;
   logic            lvlInc, lvlHold, lvlClear;

   assign fire   = instr_valid & ~stall;
   assign opLow  = opcode[2:0];
   // Only codes 0-7 exist; anything with upper bits set is illegal.
   assign opHigh = (opcode >> 3) != '0;

   always_comb begin
      ctrl     = CTRL_NOP;
      lvlInc   = 1'b0;
      lvlHold  = 1'b1;
      lvlClear = 1'b0;
      if (fire) begin
         lvlHold = 1'b0;
         if (opHigh)             ctrl = ctrlIllegal();
         else if (level == '0)   ctrl = decodeBase(opLow, last_bit);
         else                    ctrl = decodePrefix(opLow, level);

         if (ctrl.illegal) begin
            lvlClear = 1'b1;
         end else if (level == '0) begin
            lvlInc  = (opLow == OP_PREP);
            lvlHold = ~lvlInc;
         end else begin
            lvlInc   = (opLow == OP_PEXT);
            lvlHold  = (opLow == OP_PSFT);
            lvlClear = ~(lvlInc | lvlHold);
         end
      end
   end

   prefix_level_ctr #(.LVLW(LVLW), .ERRW(ERRW)) uLevelCtr (
      .clk      (clk),
      .reset    (reset),
      .inc      (lvlInc),
      .hold     (lvlHold),
      .clear    (lvlClear),
      .errInc   (ctrl.illegal),
      .level    (level),
      .errCount (err_count)
   );

   assign write_prep_reg = ctrl.writePrepReg;
   assign read_prep_reg  = ctrl.readPrepReg;
   assign write_enabled  = ctrl.writeEnabled;
   assign data_write     = ctrl.dataWrite;
   assign data_read      = ctrl.dataRead;
   assign branch         = ctrl.branch;
   assign illegal        = ctrl.illegal;
   assign alu_op         = ctrl.aluOp;
   assign mem_bank       = ctrl.memBank[LVLW-1:0];
   assign prep_level     = level;

endmodule

// File: tb/tb_prefix_ctrl_decoder.sv
module tb_prefix_ctrl_decoder;

   logic       clk = 1'b0;
   logic       reset;
   logic       instr_valid, stall, last_bit;
   logic [2:0] opcode;
   logic       write_prep_reg, read_prep_reg, write_enabled;
   logic       data_write, data_read, branch, illegal;
   logic [2:0] alu_op;
   logic [1:0] mem_bank, prep_level;
   logic [7:0] err_count;

   int checks   = 0;
   int failures = 0;
   int expErr;

   always #5 clk = ~clk;

   prefix_ctrl_decoder #(.OPW(3), .PREFIX_DEPTH(2), .ERRW(8)) dut (
      .clk(clk), .reset(reset), .instr_valid(instr_valid), .stall(stall),
      .opcode(opcode), .last_bit(last_bit),
      .write_prep_reg(write_prep_reg), .read_prep_reg(read_prep_reg),
      .write_enabled(write_enabled), .data_write(data_write),
      .data_read(data_read), .branch(branch), .alu_op(alu_op),
      .mem_bank(mem_bank), .prep_level(prep_level), .illegal(illegal),
      .err_count(err_count)
   );

   // {wpr,rpr,we,dw,dr,br,ill,alu[2:0],bank[1:0]}
   function automatic logic [11:0] ex(input logic wpr, rpr, we, dw, dr, br, ill,
                                      input logic [2:0] alu, input logic [1:0] bank);
      return {wpr, rpr, we, dw, dr, br, ill, alu, bank};
   endfunction

   function automatic logic [11:0] outv();
      return {write_prep_reg, read_prep_reg, write_enabled, data_write, data_read,
              branch, illegal, alu_op, mem_bank};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs just after an edge, check decode mid-cycle,
   // then check the registered level just after the next edge.
   task automatic cyc(input logic v, s, input logic [2:0] op, input logic lb,
                      input string tag, input logic [11:0] expV, input logic [1:0] expLvl);
      instr_valid = v; stall = s; opcode = op; last_bit = lb;
      #2;
      chk({tag, ".dec"}, 32'(outv()), 32'(expV));
      @(posedge clk); #1;
      chk({tag, ".lvl"}, 32'(prep_level), 32'(expLvl));
   endtask

   initial begin
      reset = 1'b0; instr_valid = 1'b0; stall = 1'b0; opcode = 3'd0; last_bit = 1'b0;
      #1;
      chk("rst.lvl", 32'(prep_level), 32'd0);
      chk("rst.err", 32'(err_count), 32'd0);
      chk("rst.dec", 32'(outv()), 32'd0);
      @(posedge clk); #1;
      reset = 1'b1;

      // Base-table arithmetic
      cyc(1, 0, 3'b001, 1, "inc",  ex(0,0,1,0,0,0,0,3'd0,2'd0), 2'd0);
      cyc(1, 0, 3'b001, 0, "dec",  ex(0,0,1,0,0,0,0,3'd1,2'd0), 2'd0);
      cyc(1, 0, 3'b011, 0, "xorr", ex(0,0,1,0,0,0,0,3'd3,2'd0), 2'd0);
      cyc(0, 0, 3'b111, 0, "idle", ex(0,0,0,0,0,0,0,3'd0,2'd0), 2'd0);
      chk("idle.err", 32'(err_count), 32'd0);

      // PREP then LW
      cyc(1, 0, 3'b000, 0, "prep", ex(1,0,1,0,0,0,0,3'd0,2'd0), 2'd1);
      cyc(1, 0, 3'b010, 0, "lw1",  ex(0,1,1,0,1,0,0,3'd0,2'd0), 2'd0);

      // PREP then BEQ
      cyc(1, 0, 3'b000, 0, "prep2", ex(1,0,1,0,0,0,0,3'd0,2'd0), 2'd1);
      cyc(1, 0, 3'b001, 0, "beq",   ex(0,1,0,0,0,1,0,3'd2,2'd0), 2'd0);

      // PSFT repeat and stall hold
      cyc(1, 0, 3'b000, 0, "prep3", ex(1,0,1,0,0,0,0,3'd0,2'd0), 2'd1);
      cyc(1, 0, 3'b101, 0, "psft1", ex(1,1,1,0,0,0,0,3'd4,2'd0), 2'd1);
      cyc(1, 0, 3'b101, 0, "psft2", ex(1,1,1,0,0,0,0,3'd4,2'd0), 2'd1);
      for (int i = 0; i < 3; i++)
         cyc(1, 1, 3'b000, 0, "stall", ex(0,0,0,0,0,0,0,3'd0,2'd0), 2'd1);
      cyc(1, 0, 3'b000, 0, "andi", ex(0,1,1,0,0,0,0,3'd6,2'd0), 2'd0);
      chk("andi.err", 32'(err_count), 32'd0);

      // Two-level prefix: SW into bank 1
      cyc(1, 0, 3'b000, 0, "prep4", ex(1,0,1,0,0,0,0,3'd0,2'd0), 2'd1);
      cyc(1, 0, 3'b110, 0, "pext1", ex(1,1,0,0,0,0,0,3'd0,2'd0), 2'd2);
      cyc(1, 0, 3'b011, 0, "sw2",   ex(0,1,0,1,0,0,0,3'd0,2'd1), 2'd0);

      // PEXT at saturation is illegal
      cyc(1, 0, 3'b000, 0, "prep5", ex(1,0,1,0,0,0,0,3'd0,2'd0), 2'd1);
      cyc(1, 0, 3'b110, 0, "pext2", ex(1,1,0,0,0,0,0,3'd0,2'd0), 2'd2);
      cyc(1, 0, 3'b110, 0, "pextX", ex(0,0,0,0,0,0,1,3'd0,2'd0), 2'd0);
      chk("pextX.err", 32'(err_count), 32'd1);

      // 111 at level 1 is illegal and aborts the prefix
      cyc(1, 0, 3'b000, 0, "prep6", ex(1,0,1,0,0,0,0,3'd0,2'd0), 2'd1);
      cyc(1, 0, 3'b111, 0, "ill1",  ex(0,0,0,0,0,0,1,3'd0,2'd0), 2'd0);
      chk("ill1.err", 32'(err_count), 32'd2);

      // Saturation
      expErr = 2;
      for (int i = 0; i < 260; i++) begin
         cyc(1, 0, 3'b111, 0, "sat", ex(0,0,0,0,0,0,1,3'd0,2'd0), 2'd0);
         if (expErr < 255) expErr++;
         chk("sat.err", 32'(err_count), 32'(expErr));
      end
      chk("sat.final", 32'(err_count), 32'd255);

      // Async reset mid-prefix
      cyc(1, 0, 3'b000, 0, "prep7", ex(1,0,1,0,0,0,0,3'd0,2'd0), 2'd1);
      instr_valid = 1'b0;
      reset = 1'b0;
      #1;
      chk("arst.lvl", 32'(prep_level), 32'd0);
      chk("arst.err", 32'(err_count), 32'd0);
      #2;
      reset = 1'b1;
      cyc(1, 0, 3'b000, 0, "postrst", ex(1,0,1,0,0,0,0,3'd0,2'd0), 2'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/prefix_ctrl_decoder.md
# prefix_ctrl_decoder

Parametrised instruction control decoder with a multi-level prefix state machine, between instruction fetch and the register file / ALU / data memory. Decodes the opcode against a table selected by the current prefix level: level 0 is the base set, level 1 and above is the prefixed set. Supports up to PREFIX_DEPTH stacked prefixes, where deeper levels select a data-memory bank. Adds a valid/stall qualifier, illegal-opcode detection with prefix abort, and a saturating error counter.

## Interface
- OPW, 3: opcode width; only codes 0–7 are defined, and any code ≥8 is illegal.
- PREFIX_DEPTH, 2: maximum prefix level (≥1).
- LVLW, $clog2(PREFIX_DEPTH+1): level width (derived, not overridden).
- ERRW, 8: error counter width.
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- instr_valid  in  1  opcode/last_bit valid this cycle.
- stall  in  1  pipeline hold; instruction not consumed.
- opcode  in  OPW  instruction opcode.
- last_bit  in  1  instruction LSB; selects INC (1) or DEC (0).
- write_prep_reg, read_prep_reg, write_enabled, data_write, data_read, branch  out  1  datapath enables.
- alu_op  out  3  ALU operation code.
- mem_bank  out  LVLW  bank for LW/SW; equals level-1, and is 0 otherwise.
- prep_level  out  LVLW  current prefix level (registered).
- illegal  out  1  illegal opcode consumed this cycle.
- err_count  out  ERRW  saturating count of illegal opcodes.

## Operation
- An instruction is consumed when fire = instr_valid & ~stall. When fire=0:
  - all enables, illegal, alu_op and mem_bank are 0;
  - state and err_count hold.
- ALU codes: ADD 000, SUB 001, XOR 010, RXOR 011, SLL 100, SRL 101, AND 110.
- Level 0 table:
  - 000 PREP: write_prep_reg, write_enabled. Level → 1.
  - 001 INC/DEC: write_enabled. alu_op ADD if last_bit=1, else SUB.
  - 010 XOR: write_enabled. alu_op XOR.
  - 011 XORR: write_enabled. alu_op RXOR.
  - 100 SLL: write_enabled. alu_op SLL.
  - 101 SRL: write_enabled. alu_op SRL.
  - 110, 111: illegal.
- Level k≥1 table. read_prep_reg=1 on every legal opcode. Unless stated otherwise, the level → 0 after the instruction.
  - 000 ANDI: write_enabled. alu_op AND.
  - 001 BEQ: branch. alu_op XOR.
  - 010 LW: write_enabled, data_read. alu_op ADD. mem_bank=k-1.
  - 011 SW: data_write. alu_op ADD. mem_bank=k-1.
  - 100 SAVE: write_enabled. alu_op ADD.
  - 101 PSFT: write_prep_reg, write_enabled. alu_op SLL. Level holds at k.
  - 110 PEXT: write_prep_reg. Level → k+1. Illegal if k=PREFIX_DEPTH.
  - 111: illegal.
- Illegal opcode handling:
  - all enables 0 and alu_op 0;
  - illegal=1;
  - level → 0 (prefix aborted);
  - err_count increments and saturates at all-ones.
- Decode outputs are combinational from opcode, last_bit, fire and the registered level. There are no combinational paths from the outputs back to the inputs.

## Timing
- Decode latency 0: outputs are valid in the same cycle as the opcode. The level update is visible in the next cycle.
- On reset assertion (asynchronous):
  - prep_level=0 and err_count=0 immediately;
  - combinational outputs follow level 0.
- Reset asserted mid-prefix discards the prefix. The first instruction after reset release decodes at level 0.
- A stall during prefix level k holds k indefinitely. The stalled opcode is re-presented and decoded again with the same result.
- PSFT may repeat without limit at any level ≥1.
- Level never exceeds PREFIX_DEPTH. At saturation, PEXT is illegal and the level returns to 0.
- err_count is at all-ones and an illegal opcode fires: the count holds and illegal still pulses.

## Structure
- Package ctrl_pkg holds:
  - alu_op_e enum;
  - opcode localparams (OP_PREP, OP_INC, …, OP_PEXT);
  - ctrl_t struct bundling the enables, alu_op and mem_bank, with a CTRL_NOP constant.
- Sub-module prefix_level_ctr, which contains:
  - the level register, with next-level inputs inc/hold/clear;
  - the saturating err_count register;
  - both registers reset asynchronously.
- The top level contains only the two decode tables, implemented as functions that return ctrl_t.

## Test plan
- Reset, then fire 001 with last_bit=1, then last_bit=0 → write_enabled=1, alu_op 000 then 001. prep_level stays 0.
- Fire 000 (PREP), then 010 (LW) → cycle 1: write_prep_reg=1, prep_level becomes 1. Cycle 2: read_prep_reg=1, data_read=1, mem_bank=0, level returns to 0.
- Fire PREP, then PEXT, then 011 (SW), with PREFIX_DEPTH=2 → levels 1 then 2. SW gives data_write=1, mem_bank=1, level returns to 0. A second PEXT at level 2 instead gives illegal=1 and level 0.
- Fire PREP, PSFT, PSFT, then stall=1 for 3 cycles with 000 presented, then release → level stays 1 throughout. ANDI fires once (alu_op 110), err_count=0.
- Fire 111 at level 0 260 times with ERRW=8 → illegal pulses every cycle, err_count saturates at 255.
- At level 1, assert reset for a partial cycle, then release and fire 000 → prep_level=0 and err_count=0 immediately on reset assertion. After release, 000 decodes as PREP.
